roberts_mdc_job_sequencer: RTL and testbench

Job-level controller for the Roberts MDC kernel adapter. It accepts a job descriptor (input pel count, expected output count) and issues the kernel start pulse. It then sequences the `in_size` and `in_pel` sink streams through enable gates and counts output handshakes until the job completes. It sits between the HWPE control FSM and the kernel adapter, and replaces the adapter's fixed "one input → ready" assumption with explicit per-job counts and a watchdog.

---
 rtl/roberts_mdc_job_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_roberts_mdc_job_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roberts_mdc_job_sequencer.sv
// Job-level sequencer for the Roberts MDC kernel adapter: it starts the kernel, gates the size/pel
// sink streams, and counts outputs against per-job descriptor counts, with an idle watchdog.
module roberts_mdc_job_sequencer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic [CNT_W-1:0] job_n_in_i,
    input  logic [CNT_W-1:0] job_n_out_i,
    output logic             kernel_start_o,
    output logic             size_en_o,
    output logic             pel_en_o,
    input  logic             size_hs_i,
    input  logic             pel_hs_i,
    input  logic             out_hs_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             err_o,
    input  logic             clear_i,
    output logic [CNT_W-1:0] in_cnt_o,
    output logic [CNT_W-1:0] out_cnt_o
);

    localparam int unsigned      WD_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               WD_EN    = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SIZE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_in_q, n_in_d;
    logic [CNT_W-1:0] n_out_q, n_out_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             size_en_q, size_en_d;
    logic             pel_en_q, pel_en_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic             active;
    logic             out_window;
    logic             size_ok;
    logic             pel_ok;
    logic             out_ok;
    logic             out_bad;
    logic             any_hs;
    logic             wd_hit;
    logic [WD_W-1:0]  wd_inc;

    // Handshake: a descriptor transfers on a cycle with job_valid_i and job_ready_o both high;
    // the *_hs_i inputs are already-qualified valid&ready observations of the gated streams.
    always_comb begin
        active     = ((state_q == ST_SIZE) || (state_q == ST_STREAM) || (state_q == ST_DRAIN)) && !timeout_q;
        out_window = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && !timeout_q;
        size_ok    = size_hs_i && size_en_q;
        pel_ok     = pel_hs_i && pel_en_q;
        out_ok     = out_hs_i && out_window && (out_cnt_q < n_out_q);
        out_bad    = out_hs_i && ((state_q == ST_IDLE) || (state_q == ST_START) ||
                                  (state_q == ST_SIZE) || (state_q == ST_DONE) ||
                                  (out_window && (out_cnt_q >= n_out_q)));
        any_hs     = size_hs_i || pel_hs_i || out_hs_i;

        err_d = err_q;
        if (out_bad || (pel_hs_i && !pel_en_q) || (size_hs_i && !size_en_q)) begin
            err_d = 1'b1;
        end else if (clear_i) begin
            err_d = 1'b0;
        end

        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (state_q == ST_START) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (pel_ok) in_cnt_d = in_cnt_q + CNT_ONE;
            if (out_ok) out_cnt_d = out_cnt_q + CNT_ONE;
        end

        state_d = state_q;
        n_in_d  = n_in_q;
        n_out_d = n_out_q;
        if (timeout_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_valid_i) begin
                        n_in_d  = job_n_in_i;
                        n_out_d = job_n_out_i;
                        state_d = (job_n_out_i == '0) ? ST_DONE : ST_START;
                    end
                end
                ST_START: state_d = ST_SIZE;
                ST_SIZE: begin
                    if (size_ok) state_d = (n_in_q == '0) ? ST_DRAIN : ST_STREAM;
                end
                ST_STREAM: begin
                    if (pel_ok && (in_cnt_q == n_in_q - CNT_ONE)) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_cnt_d == n_out_q) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Idle-cycle watchdog; on expiry the state is held one extra cycle so timeout_o
        // is seen while busy, and the enables drop together with the pulse.
        wd_inc = wd_q + WD_ONE;
        wd_hit = 1'b0;
        wd_d   = '0;
        if (WD_EN && active && !any_hs && (state_d == state_q)) begin
            wd_d   = wd_inc;
            wd_hit = (wd_inc == WD_LIMIT);
        end

        timeout_d = wd_hit;
        start_d   = (state_d == ST_START);
        size_en_d = (state_d == ST_SIZE) && !wd_hit;
        pel_en_d  = (state_d == ST_STREAM) && !wd_hit;
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            n_in_q    <= '0;
            n_out_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            size_en_q <= 1'b0;
            pel_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_in_q    <= n_in_d;
            n_out_q   <= n_out_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            start_q   <= start_d;
            size_en_q <= size_en_d;
            pel_en_q  <= pel_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign job_ready_o    = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign kernel_start_o = start_q;
    assign size_en_o      = size_en_q;
    assign pel_en_o       = pel_en_q;
    assign done_o         = done_q;
    assign timeout_o      = timeout_q;
    assign err_o          = err_q;
    assign in_cnt_o       = in_cnt_q;
    assign out_cnt_o      = out_cnt_q;

endmodule

// File: tb/tb_roberts_mdc_job_sequencer.sv
// Bench for roberts_mdc_job_sequencer: scenario tasks with inline checks and a job-result
// scoreboard holding {timeout, in_cnt, out_cnt} per submitted job.
module tb_roberts_mdc_job_sequencer;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 8;
    localparam int SB_W        = 1 + 2 * CNT_W;

    logic             clk;
    logic             rst;
    logic             job_valid_i;
    logic             job_ready_o;
    logic [CNT_W-1:0] job_n_in_i;
    logic [CNT_W-1:0] job_n_out_i;
    logic             kernel_start_o;
    logic             size_en_o;
    logic             pel_en_o;
    logic             size_hs_i;
    logic             pel_hs_i;
    logic             out_hs_i;
    logic             busy_o;
    logic             done_o;
    logic             timeout_o;
    logic             err_o;
    logic             clear_i;
    logic [CNT_W-1:0] in_cnt_o;
    logic [CNT_W-1:0] out_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [SB_W-1:0] exp_q[$];

    roberts_mdc_job_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_n_in_i(job_n_in_i), .job_n_out_i(job_n_out_i),
        .kernel_start_o(kernel_start_o), .size_en_o(size_en_o), .pel_en_o(pel_en_o),
        .size_hs_i(size_hs_i), .pel_hs_i(pel_hs_i), .out_hs_i(out_hs_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .err_o(err_o),
        .clear_i(clear_i), .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s, input logic p, input logic o);
        size_hs_i = s;
        pel_hs_i  = p;
        out_hs_i  = o;
        tick();
        size_hs_i = 1'b0;
        pel_hs_i  = 1'b0;
        out_hs_i  = 1'b0;
    endtask

    task automatic submit(input logic [CNT_W-1:0] n_in, input logic [CNT_W-1:0] n_out,
                          input logic exp_to, input logic [CNT_W-1:0] exp_in,
                          input logic [CNT_W-1:0] exp_out);
        job_n_in_i  = n_in;
        job_n_out_i = n_out;
        job_valid_i = 1'b1;
        exp_q.push_back({exp_to, exp_in, exp_out});
        step(1'b0, 1'b0, 1'b0);
        job_valid_i = 1'b0;
    endtask

    // scoreboard: pop and compare when the DUT ends a job
    task automatic wait_job_end(input int budget, input string name);
        logic [SB_W-1:0] exp_v;
        logic [SB_W-1:0] act_v;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_o || timeout_o) begin
                seen = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 1'b0);
        end
        if (done_o || timeout_o) seen = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_end: no done/timeout within %0d cycles", name, budget);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_end: unexpected job end, got %h with empty queue", name,
                     {timeout_o, in_cnt_o, out_cnt_o});
        end else begin
            exp_v = exp_q.pop_front();
            act_v = {timeout_o, in_cnt_o, out_cnt_o};
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s_result: got {to,in,out}=%h expected %h", name, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst = 1'b1;
        tick();
        tick();
        flags = {job_ready_o, busy_o, kernel_start_o, size_en_o, pel_en_o, done_o, timeout_o, err_o};
        checks++;
        if (flags !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 10000000", flags);
        end
        checks++;
        if ({in_cnt_o, out_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_counts: got %h/%h expected 0/0", in_cnt_o, out_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_out();
        submit(16'd5, 16'd0, 1'b0, 16'd0, 16'd0);
        checks++;
        if ({kernel_start_o, size_en_o, pel_en_o, done_o} !== 4'b0001) begin
            errors++;
            $display("FAIL zero_t1: got start/size/pel/done=%b expected 0001",
                     {kernel_start_o, size_en_o, pel_en_o, done_o});
        end
        wait_job_end(1, "zero");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if ({kernel_start_o, size_en_o, pel_en_o, job_ready_o} !== 4'b0001) begin
                errors++;
                $display("FAIL zero_after: got start/size/pel/ready=%b expected 0001",
                         {kernel_start_o, size_en_o, pel_en_o, job_ready_o});
            end
        end
    endtask

    task automatic test_basic();
        int dones;
        checks++;
        if (job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b expected 1", job_ready_o);
        end
        submit(16'd4, 16'd4, 1'b0, 16'd4, 16'd4);
        checks++;
        if ({kernel_start_o, busy_o} !== 2'b11) begin
            errors++;
            $display("FAIL basic_start: got start/busy=%b expected 11", {kernel_start_o, busy_o});
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({size_en_o, kernel_start_o, in_cnt_o} !== {2'b10, 16'd0}) begin
            errors++;
            $display("FAIL basic_size: got size/start=%b in=%0d expected 10 0",
                     {size_en_o, kernel_start_o}, in_cnt_o);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if ({pel_en_o, size_en_o} !== 2'b10) begin
            errors++;
            $display("FAIL basic_pel_en: got pel/size=%b expected 10", {pel_en_o, size_en_o});
        end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_o) dones++;
            if (i == 4) begin
                checks++;
                if (pel_en_o !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_pel_drop: got %b expected 0", pel_en_o);
                end
            end
            step(1'b0, i < 4, i >= 2);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL basic_early_done: got %0d pulses expected 0", dones);
        end
        wait_job_end(4, "basic");
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({done_o, job_ready_o, err_o} !== 3'b010) begin
            errors++;
            $display("FAIL basic_after: got done/ready/err=%b expected 010", {done_o, job_ready_o, err_o});
        end
    endtask

    task automatic test_error();
        submit(16'd3, 16'd1, 1'b0, 16'd3, 16'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got %b expected 0", err_o);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_extra_out: got %b expected 1", err_o);
        end
        wait_job_end(3, "err");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err_o);
        end
        clear_i = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        clear_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins: got %b expected 1", err_o);
        end
        clear_i = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clear_i = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", err_o);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if ({err_o, in_cnt_o} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL err_idle_pel: got err=%b in=%0d expected 1 3", err_o, in_cnt_o);
        end
        clear_i = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clear_i = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_idle_size: got %b expected 1", err_o);
        end
        clear_i = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clear_i = 1'b0;
    endtask

    task automatic test_timeout();
        submit(16'd5, 16'd5, 1'b1, 16'd2, 16'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            checks++;
            if ({timeout_o, pel_en_o} !== 2'b01) begin
                errors++;
                $display("FAIL to_wait_%0d: got timeout/pel=%b expected 01", k, {timeout_o, pel_en_o});
            end
            step(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if ({timeout_o, pel_en_o, done_o, busy_o} !== 4'b1001) begin
            errors++;
            $display("FAIL to_pulse: got timeout/pel/done/busy=%b expected 1001",
                     {timeout_o, pel_en_o, done_o, busy_o});
        end
        wait_job_end(1, "to");
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({job_ready_o, timeout_o, done_o, in_cnt_o} !== {3'b100, 16'd2}) begin
            errors++;
            $display("FAIL to_after: got ready/to/done=%b in=%0d expected 100 2",
                     {job_ready_o, timeout_o, done_o}, in_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        submit(16'd4, 16'd4, 1'b0, 16'd4, 16'd4);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if ({pel_en_o, in_cnt_o} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL arst_pre: got pel=%b in=%0d expected 1 2", pel_en_o, in_cnt_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pel_en_o, busy_o, job_ready_o, size_en_o, kernel_start_o, done_o, timeout_o, err_o,
             in_cnt_o, out_cnt_o} !== {8'b0010_0000, 32'd0}) begin
            errors++;
            $display("FAIL arst_immediate: got pel/busy/ready=%b in=%0d out=%0d expected 001 0 0",
                     {pel_en_o, busy_o, job_ready_o}, in_cnt_o, out_cnt_o);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        submit(16'd2, 16'd2, 1'b0, 16'd2, 16'd2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        wait_job_end(3, "arst_rerun");
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        job_n_in_i  = 16'd2;
        job_n_out_i = 16'd1;
        job_valid_i = 1'b1;
        exp_q.push_back({1'b0, 16'd2, 16'd1});
        exp_q.push_back({1'b0, 16'd2, 16'd1});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        wait_job_end(4, "b2b_first");
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({job_ready_o, kernel_start_o} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_gap: got ready/start=%b expected 10", {job_ready_o, kernel_start_o});
        end
        step(1'b0, 1'b0, 1'b0);
        job_valid_i = 1'b0;
        checks++;
        if (kernel_start_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start2: got %b expected 1", kernel_start_o);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({in_cnt_o, out_cnt_o, size_en_o} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_restart: got in=%0d out=%0d size=%b expected 0 0 1",
                     in_cnt_o, out_cnt_o, size_en_o);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        wait_job_end(4, "b2b_second");
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        job_valid_i = 1'b0;
        job_n_in_i  = '0;
        job_n_out_i = '0;
        size_hs_i   = 1'b0;
        pel_hs_i    = 1'b0;
        out_hs_i    = 1'b0;
        clear_i     = 1'b0;
        test_reset();
        test_zero_out();
        test_basic();
        test_error();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
